axi4stream_rr_arbiter: RTL and testbench
========================================

Name: axi4stream_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI4-Stream output between K AXI4-Stream inputs.
- Sits between several stream sources (e.g. multiple Axi4StreamMaster BFMs or DMA engines) and a single Axi4StreamSlave / downstream sink.
- A grant is held for a whole packet (until the TLAST beat is accepted), so packets are never interleaved.

Parameters:
- K, 2, number of input streams (2..16).
- N, 4, TDATA width in bytes (TDATA = 8*N bits, TKEEP/TSTRB = N bits).
- I, 1, TID width in bits.
- D, 1, TDEST width in bits.
- U, 1, TUSER width in bits.

Ports:
- ACLK  input  1  clock; all logic on rising edge.
- ARESETn  input  1  reset, synchronous, active-low.
- S_TVALID  input  K  per-input valid.
- S_TREADY  output  K  per-input ready.
- S_TDATA  input  K*8*N  input data, input k at slice k.
- S_TSTRB  input  K*N  input byte strobes.
- S_TKEEP  input  K*N  input byte keeps.
- S_TLAST  input  K  input end-of-packet.
- S_TID  input  K*I  input IDs.
- S_TDEST  input  K*D  input destinations.
- S_TUSER  input  K*U  input user sideband.
- M_TVALID  output  1  output valid.
- M_TREADY  input  1  output ready.
- M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER  output  8*N, N, N, 1, I, D, U  output payload.
- GRANT  output  clog2(K) (min 1)  index of the input currently owning the output.
- BUSY  output  1  high while a packet grant is held.

Behaviour:
- Reset: on rising ACLK with ARESETn=0, the block goes to state IDLE with ptr=0. Outputs during and after reset: GRANT=0, BUSY=0, M_TVALID=0, S_TREADY=0. Payload outputs are don't-care, driven 0.
- States:
  - IDLE: no grant. M_TVALID=0, S_TREADY=0.
  - BUSY: input g granted. BUSY=1, GRANT=g.
- IDLE -> BUSY: the first cycle any S_TVALID is high. g = first k with S_TVALID[k]=1, searching ptr, ptr+1, ..., K-1, 0, ..., ptr-1 (modulo K). GRANT/BUSY update on the next edge, giving 1 cycle of arbitration latency.
- BUSY datapath is purely combinational, with zero added latency:
  - M_TVALID = S_TVALID[g]; all M_T* payload = input g fields.
  - S_TREADY[g] = M_TREADY; S_TREADY[k≠g] = 0.
- BUSY -> IDLE: on an edge where M_TVALID & M_TREADY & M_TLAST = 1. At the same edge ptr <= (g+1) mod K.
- After each packet there is one mandatory IDLE bubble cycle; re-arbitration happens in that cycle. No back-to-back packets across the boundary.
- While BUSY, an S_TVALID drop on g is passed through as M_TVALID=0; the grant is still held. No timeout.
- Other inputs' S_TVALID/payload are ignored while BUSY and may change freely; AXI-Stream stability is the sources' obligation.
- Single-beat packet (TLAST on first beat): BUSY for exactly 1 accepted beat, then IDLE.
- Single requester: it wins every arbitration regardless of ptr.
- K not a power of two: ptr and g wrap explicitly at K, never at 2^width.
- Reset mid-packet: state returns to IDLE immediately. The truncated packet is not completed, no TLAST is emitted, and ptr=0.
- Output transfers occur only when M_TVALID & M_TREADY. The block never asserts M_TVALID with a payload from a non-granted input.

Decomposition:
- Shared package axi4stream_pkg holds:
  - state enum {IDLE, BUSY};
  - index-width function idx_w(K) = max(1, clog2(K));
  - slice helper functions for flattened per-input vectors.
- One sub-module: rr_pick (combinational). Inputs: request vector K and ptr. Outputs: found and index. Reusable by a future AXI4-Lite arbiter.
- The top holds the FSM, ptr register and payload mux.

Test Plan:
- Reset: hold ARESETn=0 for 3 cycles with S_TVALID=2'b11 -> M_TVALID=0, S_TREADY=0, BUSY=0, GRANT=0 throughout. First grant appears 1 cycle after release, to input 0.
- Fairness, K=2, both inputs continuously sending 3-beat packets, M_TREADY=1 -> output order in0,in1,in0,in1. Each packet is 3 contiguous beats followed by 1 idle cycle. S_TREADY is never 1 on the non-granted input.
- Non-interleave under backpressure: in0 sends 4 beats (0x11..0x14); in1 requests at beat 2; M_TREADY toggles 1,0,1,0 -> output 0x11..0x14 with TLAST only on 0x14, then 1 bubble, then in1's packet. TID/TDEST/TUSER follow the source.
- Wrap, K=3, only in2 and in0 requesting, ptr=2 after an in1 packet -> grants in2 then in0 then in2. GRANT values 2,0,2.
- Single-beat and source stall: in1 sends 1 beat with TLAST (0xAB) -> BUSY for 1 transfer cycle. Then in0 drops S_TVALID mid-packet for 2 cycles -> M_TVALID=0 for those cycles, GRANT stays 0, no other input is served.
- Reset mid-packet: assert ARESETn=0 after beat 2 of a 5-beat in1 packet -> next cycle M_TVALID=0, BUSY=0. After release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/axi4stream_rr_arbiter_pkg.sv
// axi4stream_pkg: shared state type, index width and slice-offset helpers for stream arbiters
package axi4stream_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  function automatic int idx_w(int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction
  function automatic int lo(int w, int i);
    return w * i;
  endfunction
endpackage

// File: rtl/axi4stream_rr_arbiter_if.sv
// axi4stream_rr_arbiter_if: K flattened input streams, one output stream, grant status
interface axi4stream_rr_arbiter_if #(parameter int K = 2, parameter int N = 4, parameter int I = 1, parameter int D = 1, parameter int U = 1);
  localparam int W = axi4stream_pkg::idx_w(K);
  logic [K-1:0] S_TVALID, S_TREADY, S_TLAST;
  logic [K*8*N-1:0] S_TDATA;
  logic [K*N-1:0] S_TSTRB, S_TKEEP;
  logic [K*I-1:0] S_TID;
  logic [K*D-1:0] S_TDEST;
  logic [K*U-1:0] S_TUSER;
  logic M_TVALID, M_TREADY, M_TLAST;
  logic [8*N-1:0] M_TDATA;
  logic [N-1:0] M_TSTRB, M_TKEEP;
  logic [I-1:0] M_TID;
  logic [D-1:0] M_TDEST;
  logic [U-1:0] M_TUSER;
  logic [W-1:0] GRANT;
  logic BUSY;
  modport slave (
    input S_TVALID, S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER, M_TREADY,
    output S_TREADY, M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER, GRANT, BUSY
  );
  modport master (
    output S_TVALID, S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER, M_TREADY,
    input S_TREADY, M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER, GRANT, BUSY
  );
endinterface

// File: rtl/axi4stream_rr_arbiter_pick.sv
// rr_pick: first set request at or after ptr, wrapping at K
module rr_pick import axi4stream_pkg::*; #(
  parameter int K = 2,
  localparam int W = idx_w(K)
) (
  input  logic [K-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  // descending scan so the smallest offset from ptr is the last one written
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % K]) begin
        found = 1'b1;
        idx = W'((int'(ptr) + i) % K);
      end
    end
  end
endmodule

// File: rtl/axi4stream_rr_arbiter.sv
// axi4stream_rr_arbiter: packet-level round-robin share of one AXI4-Stream output among K inputs
module axi4stream_rr_arbiter import axi4stream_pkg::*; #(
  parameter int K = 2,
  parameter int N = 4,
  parameter int I = 1,
  parameter int D = 1,
  parameter int U = 1
) (
  input logic ACLK,
  input logic ARESETn,
  axi4stream_rr_arbiter_if.slave bus
);
  localparam int W = idx_w(K);
  state_e state_q, state_d;
  logic [W-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx;
  logic pick_found, busy, done;
  rr_pick #(.K(K)) u_pick (.req(bus.S_TVALID), .ptr(ptr_q), .found(pick_found), .idx(pick_idx));
  assign busy = state_q == BUSY;
  always_comb begin
    bus.BUSY = busy;
    bus.GRANT = busy ? grant_q : '0;
    bus.M_TVALID = busy & bus.S_TVALID[grant_q];
    bus.M_TDATA = busy ? bus.S_TDATA[lo(8*N, int'(grant_q)) +: 8*N] : '0;
    bus.M_TSTRB = busy ? bus.S_TSTRB[lo(N, int'(grant_q)) +: N] : '0;
    bus.M_TKEEP = busy ? bus.S_TKEEP[lo(N, int'(grant_q)) +: N] : '0;
    bus.M_TLAST = busy & bus.S_TLAST[grant_q];
    bus.M_TID = busy ? bus.S_TID[lo(I, int'(grant_q)) +: I] : '0;
    bus.M_TDEST = busy ? bus.S_TDEST[lo(D, int'(grant_q)) +: D] : '0;
    bus.M_TUSER = busy ? bus.S_TUSER[lo(U, int'(grant_q)) +: U] : '0;
    bus.S_TREADY = busy ? (K'(bus.M_TREADY) << grant_q) : '0;
    done = bus.M_TVALID & bus.M_TREADY & bus.M_TLAST;
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    if (!busy && pick_found) begin
      state_d = BUSY;
      grant_d = pick_idx;
    end
    // explicit wrap at K so non-power-of-two K never yields an out-of-range pointer
    if (busy && done) begin
      state_d = IDLE;
      ptr_d = (int'(grant_q) == K - 1) ? '0 : grant_q + 1'b1;
    end
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_axi4stream_rr_arbiter.sv
// tb_axi4stream_rr_arbiter: queue-fed sources, scoreboard monitor on the output stream
module tb_axi4stream_rr_arbiter;
  import axi4stream_pkg::*;
  localparam int K = 3, N = 4, I = 2, D = 2, U = 2;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0] strb;
    logic [3:0] keep;
    logic last;
    logic [1:0] id;
    logic [1:0] dest;
    logic [1:0] user;
  } beat_t;
  typedef struct packed {
    beat_t b;
    logic [1:0] g;
  } exp_t;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  beat_t src_q[K][$];
  exp_t exq[$];
  bit stall[K];
  bit tog;
  bit prev_last;
  int checks, errors;
  axi4stream_rr_arbiter_if #(.K(K), .N(N), .I(I), .D(D), .U(U)) bus();
  axi4stream_rr_arbiter #(.K(K), .N(N), .I(I), .D(D), .U(U)) dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));
  always #5 ACLK = ~ACLK;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge ACLK);
    #2;
  endtask
  function automatic int pending();
    int s = 0;
    for (int k = 0; k < K; k++) s += src_q[k].size();
    return s;
  endfunction
  task automatic pkt(int k, logic [31:0] base, int n, logic [1:0] id, logic [1:0] dest, logic [1:0] user, int nexp);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b = {base + 32'(i), 4'(i) + 4'h1, 4'hF - 4'(i), i == n - 1, id, dest, user};
      src_q[k].push_back(b);
      if (i < nexp) exq.push_back({b, 2'(k)});
    end
  endtask
  task automatic wait_size(int k, int n);
    for (int t = 0; t < 200 && src_q[k].size() != n; t++) step;
    chk("wait_src", 64'(src_q[k].size()), 64'(n));
  endtask
  task automatic drain;
    for (int t = 0; t < 500 && (exq.size() != 0 || pending() != 0 || bus.BUSY); t++) step;
    chk("drain_exp", 64'(exq.size()), 64'd0);
    chk("drain_busy", 64'(bus.BUSY), 64'd0);
  endtask
  // source and sink driver: changes only on the falling edge
  initial begin
    bus.M_TREADY = 1'b1;
    bus.S_TVALID = '0;
    bus.S_TDATA = '0;
    bus.S_TSTRB = '0;
    bus.S_TKEEP = '0;
    bus.S_TLAST = '0;
    bus.S_TID = '0;
    bus.S_TDEST = '0;
    bus.S_TUSER = '0;
    forever begin
      @(negedge ACLK);
      bus.M_TREADY = tog ? ~bus.M_TREADY : 1'b1;
      for (int k = 0; k < K; k++) begin
        beat_t b;
        b = src_q[k].size() != 0 ? src_q[k][0] : '0;
        bus.S_TVALID[k] = src_q[k].size() != 0 && !stall[k];
        bus.S_TDATA[k*32 +: 32] = b.data;
        bus.S_TSTRB[k*4 +: 4] = b.strb;
        bus.S_TKEEP[k*4 +: 4] = b.keep;
        bus.S_TLAST[k] = b.last;
        bus.S_TID[k*2 +: 2] = b.id;
        bus.S_TDEST[k*2 +: 2] = b.dest;
        bus.S_TUSER[k*2 +: 2] = b.user;
      end
    end
  end
  // monitor: samples 1ns before each rising edge
  initial forever begin
    @(negedge ACLK);
    #4;
    if (ARESETn && bus.M_TVALID && bus.M_TREADY) begin
      exp_t e;
      beat_t a;
      a = {bus.M_TDATA, bus.M_TSTRB, bus.M_TKEEP, bus.M_TLAST, bus.M_TID, bus.M_TDEST, bus.M_TUSER};
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", a);
      end else begin
        e = exq.pop_front();
        chk("beat", 64'(a), 64'(e.b));
        chk("beat_grant", 64'(bus.GRANT), 64'(e.g));
      end
    end
    if (prev_last) chk("bubble_busy", 64'(bus.BUSY), 64'd0);
    if (bus.BUSY) chk("ready_onehot", 64'(bus.S_TREADY & ~(3'b001 << bus.GRANT)), 64'd0);
    else chk("idle_quiet", 64'({bus.M_TVALID, bus.S_TREADY}), 64'd0);
    prev_last = ARESETn && bus.M_TVALID && bus.M_TREADY && bus.M_TLAST;
    for (int k = 0; k < K; k++)
      if (ARESETn && bus.S_TVALID[k] && bus.S_TREADY[k]) void'(src_q[k].pop_front());
  end
  initial begin
    pkt(0, 32'hA0, 3, 2'd1, 2'd0, 2'd1, 3);
    pkt(1, 32'hB0, 3, 2'd2, 2'd1, 2'd0, 3);
    pkt(0, 32'hC0, 3, 2'd3, 2'd2, 2'd1, 3);
    pkt(1, 32'hD0, 3, 2'd0, 2'd3, 2'd2, 3);
    repeat (3) begin
      step;
      chk("rst_busy", 64'(bus.BUSY), 64'd0);
      chk("rst_grant", 64'(bus.GRANT), 64'd0);
      chk("rst_mvalid", 64'(bus.M_TVALID), 64'd0);
      chk("rst_sready", 64'(bus.S_TREADY), 64'd0);
    end
    ARESETn = 1'b1;
    step;
    chk("first_busy", 64'(bus.BUSY), 64'd1);
    chk("first_grant", 64'(bus.GRANT), 64'd0);
    drain;
    tog = 1'b1;
    pkt(0, 32'h11, 4, 2'd1, 2'd2, 2'd3, 4);
    wait_size(0, 3);
    pkt(1, 32'h21, 2, 2'd2, 2'd1, 2'd0, 2);
    drain;
    tog = 1'b0;
    pkt(2, 32'h31, 2, 2'd3, 2'd3, 2'd3, 2);
    pkt(0, 32'h41, 2, 2'd0, 2'd1, 2'd2, 2);
    pkt(2, 32'h35, 2, 2'd1, 2'd0, 2'd3, 2);
    drain;
    pkt(1, 32'hAB, 1, 2'd1, 2'd1, 2'd1, 1);
    drain;
    pkt(0, 32'hC1, 3, 2'd2, 2'd0, 2'd1, 3);
    wait_size(0, 2);
    stall[0] = 1'b1;
    pkt(2, 32'hE1, 1, 2'd3, 2'd2, 2'd1, 1);
    repeat (2) begin
      step;
      chk("stall_mvalid", 64'(bus.M_TVALID), 64'd0);
      chk("stall_grant", 64'(bus.GRANT), 64'd0);
      chk("stall_busy", 64'(bus.BUSY), 64'd1);
    end
    stall[0] = 1'b0;
    drain;
    pkt(0, 32'h50, 1, 2'd0, 2'd0, 2'd0, 1);
    drain;
    pkt(1, 32'h51, 5, 2'd1, 2'd2, 2'd3, 2);
    wait_size(1, 3);
    ARESETn = 1'b0;
    src_q[1].delete();
    step;
    chk("mid_busy", 64'(bus.BUSY), 64'd0);
    chk("mid_mvalid", 64'(bus.M_TVALID), 64'd0);
    pkt(0, 32'h71, 2, 2'd2, 2'd2, 2'd2, 2);
    pkt(1, 32'h61, 2, 2'd3, 2'd1, 2'd0, 2);
    step;
    ARESETn = 1'b1;
    step;
    chk("restart_busy", 64'(bus.BUSY), 64'd1);
    chk("restart_grant", 64'(bus.GRANT), 64'd0);
    drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
